// File: rtl/baby_spi_loader.sv
// SPI-mode-0 target that lets an external host write or read words of the
// shared store; it stalls the CPU while it owns the store port.
module baby_spi_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              spi_clock_i,
  input  logic              spi_cs_i,
  input  logic              spi_pico_i,
  output logic              spi_poci_o,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_we_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              cpu_hold_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE, CMD, DATA_IN, WRITE, FETCH, DATA_OUT, DONE
  } state_t;

  state_t              state;
  logic                sck_s1, sck_s2, sck_prev;
  logic                cs_s1, cs_s2, cs_prev;
  logic                pico_s1, pico_s2;
  logic [1:0]          settle;
  logic                armed;
  logic [CNT_W-1:0]    bit_cnt;
  logic [6:0]          cmd_q;
  logic [DATA_W-1:0]   shift_q;
  logic [ADDR_W-1:0]   loader_addr;
  logic                loader_we;

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  always_ff @(posedge clock) begin
    if (reset_i) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_prev <= 1'b0;
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      cs_prev  <= 1'b1;
      pico_s1  <= 1'b0;
      pico_s2  <= 1'b0;
    end else begin
      sck_s1   <= spi_clock_i;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      cs_s1    <= spi_cs_i;
      cs_s2    <= cs_s1;
      cs_prev  <= cs_s2;
      pico_s1  <= spi_pico_i;
      pico_s2  <= pico_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_prev;
  assign sck_fall = ~sck_s2 & sck_prev;
  assign cs_rise  = cs_s2 & ~cs_prev;
  // A frame may only start once CS has been seen high after reset, so a
  // frame cut by reset is ignored until the host deselects and reselects.
  assign cs_fall  = armed & cs_prev & ~cs_s2;

  always_ff @(posedge clock) begin
    if (reset_i) begin
      state       <= IDLE;
      settle      <= 2'b00;
      armed       <= 1'b0;
      bit_cnt     <= '0;
      cmd_q       <= '0;
      shift_q     <= '0;
      loader_addr <= '0;
      loader_we   <= 1'b0;
      cpu_hold_o  <= 1'b0;
      spi_poci_o  <= 1'b0;
    end else begin
      settle    <= {settle[0], 1'b1};
      armed     <= armed | (settle[1] & cs_s2);
      loader_we <= 1'b0;
      if (state != IDLE && state != WRITE && cs_rise) begin
        state      <= IDLE;
        cpu_hold_o <= 1'b0;
        spi_poci_o <= 1'b0;
        bit_cnt    <= '0;
        cmd_q      <= '0;
        shift_q    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state      <= CMD;
              cpu_hold_o <= 1'b1;
              bit_cnt    <= '0;
              cmd_q      <= '0;
            end
          end
          CMD: begin
            if (sck_rise) begin
              cmd_q   <= {cmd_q[5:0], pico_s2};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(7)) begin
                bit_cnt     <= '0;
                loader_addr <= ADDR_W'({cmd_q[3:0], pico_s2});
                state       <= cmd_q[6] ? DATA_IN : FETCH;
              end
            end
          end
          DATA_IN: begin
            if (sck_rise) begin
              shift_q <= {shift_q[DATA_W-2:0], pico_s2};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                loader_we <= 1'b1;
                state     <= WRITE;
              end
            end
          end
          WRITE: begin
            // The write strobe is already on the port this cycle, so a
            // coinciding CS rise still lets it complete.
            if (cs_rise) begin
              state      <= IDLE;
              cpu_hold_o <= 1'b0;
            end else begin
              state <= DONE;
            end
          end
          FETCH: begin
            shift_q    <= ram_data_i;
            spi_poci_o <= ram_data_i[DATA_W-1];
            bit_cnt    <= '0;
            state      <= DATA_OUT;
          end
          DATA_OUT: begin
            // The falling edge that closes the command byte must not shift:
            // the host has not sampled the MSB yet.
            if (sck_rise) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                spi_poci_o <= 1'b0;
                state      <= DONE;
              end
            end else if (sck_fall && bit_cnt != '0) begin
              spi_poci_o <= shift_q[DATA_W-2];
              shift_q    <= {shift_q[DATA_W-2:0], 1'b0};
            end
          end
          DONE: begin
            spi_poci_o <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign ram_addr_o = cpu_hold_o ? loader_addr : cpu_addr_i;
  assign ram_data_o = cpu_hold_o ? shift_q     : cpu_data_i;
  assign ram_we_o   = cpu_hold_o ? loader_we   : cpu_we_i;

endmodule

// File: tb/tb_baby_spi_loader.sv
// Scoreboarded bench for baby_spi_loader: an SPI host model drives frames and
// a store model answers reads; a monitor checks every loader write and read.
module tb_baby_spi_loader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset_i = 1'b1;
  logic              spi_clock_i = 1'b0;
  logic              spi_cs_i = 1'b1;
  logic              spi_pico_i = 1'b0;
  logic              spi_poci_o;
  logic [ADDR_W-1:0] cpu_addr_i = '0;
  logic [DATA_W-1:0] cpu_data_i = '0;
  logic              cpu_we_i = 1'b0;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_data_o;
  logic              ram_we_o;
  logic [DATA_W-1:0] ram_data_i;
  logic              cpu_hold_o;

  baby_spi_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset_i    (reset_i),
    .spi_clock_i(spi_clock_i),
    .spi_cs_i   (spi_cs_i),
    .spi_pico_i (spi_pico_i),
    .spi_poci_o (spi_poci_o),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_we_i   (cpu_we_i),
    .ram_addr_o (ram_addr_o),
    .ram_data_o (ram_data_o),
    .ram_we_o   (ram_we_o),
    .ram_data_i (ram_data_i),
    .cpu_hold_o (cpu_hold_o)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign ram_data_i = mem[ram_addr_o];

  always @(posedge clock) begin
    if (reset_i) mem[12] <= 32'h12345678;
    else if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_wr[$];
  logic [DATA_W-1:0] exp_rd[$];
  logic [DATA_W-1:0] got_rd[$];
  wr_t               mon_e;
  int                vectors = 0;
  int                miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: loader writes (hold high) and completed host reads are popped
  // against the expectations queued when the stimulus was issued.
  always @(negedge clock) begin
    if (!reset_i && cpu_hold_o && ram_we_o) begin
      if (exp_wr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%08h, expected no write",
                 ram_addr_o, ram_data_o);
      end else begin
        mon_e = exp_wr.pop_front();
        checkOutput("write_addr", 32'(ram_addr_o), 32'(mon_e.addr));
        checkOutput("write_data", ram_data_o, mon_e.data);
      end
    end
    if (got_rd.size() != 0) begin
      if (exp_rd.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_read: got 0x%08h, expected none", got_rd.pop_front());
      end else begin
        checkOutput("read_data", got_rd.pop_front(), exp_rd.pop_front());
      end
    end
  end

  task automatic xfer(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_pico_i = tx[i];
      repeat (8) @(negedge clock);
      rx = {rx[30:0], spi_poci_o};
      spi_clock_i = 1'b1;
      repeat (8) @(negedge clock);
      spi_clock_i = 1'b0;
    end
  endtask

  task automatic cs_release();
    repeat (8) @(negedge clock);
    spi_cs_i = 1'b1;
    @(posedge clock); #1;
    checkOutput("hold_1clk_after_cs_high", 32'(cpu_hold_o), 32'd1);
    repeat (2) @(posedge clock); #1;
    checkOutput("hold_3clk_after_cs_high", 32'(cpu_hold_o), 32'd0);
    repeat (8) @(negedge clock);
  endtask

  // One host frame; dbits < 32 produces a truncated (aborted) frame.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] data,
                               input int dbits, input int extra);
    logic [31:0] rx;
    if (dbits == DATA_W) begin
      if (cmd[7]) exp_wr.push_back({cmd[4:0], data});
      else exp_rd.push_back(data);
    end
    @(negedge clock);
    spi_cs_i = 1'b0;
    repeat (8) @(negedge clock);
    checkOutput("hold_after_cs_low", 32'(cpu_hold_o), 32'd1);
    xfer({24'h0, cmd}, 8, rx);
    checkOutput("poci_during_cmd", rx, 32'd0);
    xfer(cmd[7] ? data : 32'h0, dbits, rx);
    if (cmd[7]) checkOutput("poci_during_data_in", rx, 32'd0);
    else if (dbits == DATA_W) got_rd.push_back(rx);
    if (extra > 0) begin
      xfer(32'hFFFF_FFFF, extra, rx);
      checkOutput("poci_extra_bits", rx, 32'd0);
    end
    checkOutput("hold_in_frame", 32'(cpu_hold_o), 32'd1);
    cs_release();
  endtask

  task automatic reset_mid_read();
    logic [31:0] rx;
    @(negedge clock);
    spi_cs_i = 1'b0;
    repeat (8) @(negedge clock);
    xfer(32'h0C, 8, rx);
    xfer(32'h0, 10, rx);
    checkOutput("partial_read_bits", rx, 32'h048);
    spi_pico_i = 1'b0;
    repeat (8) @(negedge clock);
    spi_clock_i = 1'b1;
    repeat (4) @(negedge clock);
    reset_i = 1'b1;
    @(negedge clock);
    reset_i = 1'b0;
    checkOutput("poci_after_reset", 32'(spi_poci_o), 32'd0);
    checkOutput("hold_after_reset", 32'(cpu_hold_o), 32'd0);
    repeat (4) @(negedge clock);
    spi_clock_i = 1'b0;
    xfer(32'h0, 21, rx);
    checkOutput("poci_rest_of_aborted_read", rx, 32'd0);
    checkOutput("hold_rest_of_aborted_read", 32'(cpu_hold_o), 32'd0);
    repeat (8) @(negedge clock);
    spi_cs_i = 1'b1;
    repeat (12) @(negedge clock);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (4) @(negedge clock);
    reset_i = 1'b0;
    repeat (8) @(negedge clock);
    checkOutput("reset_hold", 32'(cpu_hold_o), 32'd0);
    checkOutput("reset_poci", 32'(spi_poci_o), 32'd0);
    checkOutput("reset_we", 32'(ram_we_o), 32'd0);

    cpu_addr_i = 5'd7;
    cpu_data_i = 32'hA5A5A5A5;
    cpu_we_i   = 1'b1;
    #1;
    checkOutput("pass_addr", 32'(ram_addr_o), 32'd7);
    checkOutput("pass_data", ram_data_o, 32'hA5A5A5A5);
    checkOutput("pass_we", 32'(ram_we_o), 32'd1);
    @(negedge clock);
    cpu_we_i   = 1'b0;
    cpu_addr_i = 5'd0;
    cpu_data_i = '0;

    applyStimulus(8'h85, 32'hDEADBEEF, 32, 0);
    applyStimulus(8'h0C, 32'h12345678, 32, 0);
    applyStimulus(8'h83, 32'h0000BEEF, 16, 0);
    applyStimulus(8'h83, 32'hCAFEF00D, 32, 0);
    applyStimulus(8'h03, 32'hCAFEF00D, 32, 0);
    applyStimulus(8'h05, 32'hDEADBEEF, 32, 0);
    applyStimulus(8'h89, 32'h0BADF00D, 32, 8);
    applyStimulus(8'h09, 32'h0BADF00D, 32, 0);
    applyStimulus(8'hE4, 32'h13579BDF, 32, 0);
    applyStimulus(8'h64, 32'h13579BDF, 32, 0);
    reset_mid_read();
    applyStimulus(8'h0C, 32'h12345678, 32, 0);

    repeat (20) @(negedge clock);
    checkOutput("pending_writes", 32'(exp_wr.size()), 32'd0);
    checkOutput("pending_reads", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
